// File: rtl/mul_seq_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
// The caller drives the master side; mul_seq_ctrl sits on the slave side.
interface mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, a, b, input ready, busy, done, hi, lo);
    modport slave  (input start, a, b, output ready, busy, done, hi, lo);
endinterface

// File: rtl/mul_seq_ctrl.sv
// Unsigned 32x32->64 shift-and-add multiplier: one ripple-carry adder reused per cycle,
// sequenced by an IDLE/BUSY/DONE FSM. The product lands in {hi, lo}.
module add_new (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        c_in,
    output logic [31:0] s,
    output logic        c_out
);
    logic carry;

    always_comb begin
        s     = '0;
        carry = c_in;
        for (int i = 0; i < 32; i++) begin
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        c_out = carry;
    end
endmodule

module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic    clk,
    input logic    reset,
    mul_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             ready_c;
    logic             busy_c;
    logic             done_c;
    logic             last_iter;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] add_s;
    logic             add_c;

    // The multiplier bit currently at lo[0] gates the multiplicand into the adder.
    assign add_y     = lo_r[0] ? mcand : '0;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    add_new u_add (
        .x     (hi_r),
        .y     (add_y),
        .c_in  (1'b0),
        .s     (add_s),
        .c_out (add_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy_c = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                ready_c = 1'b1;
                // Accepting straight out of DONE gives back-to-back throughput.
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The adder carry enters at product bit 63 as the 65-bit {c, s, lo} shifts right.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            mcand <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else if (accept) begin
            cnt   <= '0;
            mcand <= bus.a;
            hi_r  <= '0;
            lo_r  <= bus.b;
        end else if (state == BUSY) begin
            {hi_r, lo_r} <= {add_c, add_s, lo_r[WIDTH-1:1]};
            cnt          <= cnt + 1'b1;
        end
    end

    assign bus.ready = ready_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a per-cycle comparison against an arithmetic model of the
// handshake and partial product, directed literal cases, then randomized traffic.
module tb_mul_seq_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    bit   chk_en;

    mul_seq_if #(.WIDTH(32)) bus ();

    mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an operation in flight with k iterations done, or an idle hold value.
    bit          m_in;
    int          m_k;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [63:0] m_hold;

    // After k iterations {hi,lo} = (a * low k bits of b) << (32-k), plus the unused b bits.
    function automatic logic [63:0] partial(input logic [31:0] a_i, input logic [31:0] b_i, input int k);
        logic [63:0] mask;
        logic [63:0] acc;
        mask = (64'd1 << k) - 64'd1;
        acc  = 64'(a_i) * (64'(b_i) & mask);
        return (acc << (32 - k)) + (64'(b_i) >> k);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_in   = 1'b0;
            m_k    = 0;
            m_hold = 64'd0;
        end else if (m_in && m_k < 32) begin
            m_k = m_k + 1;
        end else begin
            if (m_in) begin
                m_hold = 64'(m_a) * 64'(m_b);
                m_in   = 1'b0;
            end
            if (bus.start) begin
                m_in = 1'b1;
                m_k  = 0;
                m_a  = bus.a;
                m_b  = bus.b;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_busy;
            logic e_done;
            e_busy = m_in && (m_k < 32);
            e_done = m_in && (m_k == 32);
            check("ctrl rdy/busy/done", 64'({bus.ready, bus.busy, bus.done}), 64'({~e_busy, e_busy, e_done}));
            check("product hi:lo", {bus.hi, bus.lo}, m_in ? partial(m_a, m_b, m_k) : m_hold);
        end
    end

    task automatic launch(input logic [31:0] a_i, input logic [31:0] b_i);
        bus.start = 1'b1;
        bus.a     = a_i;
        bus.b     = b_i;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called in the first cycle after the accepting edge; returns in the done cycle.
    task automatic wait_done(input logic [31:0] eh, input logic [31:0] el, input string nm, input int inj);
        int cyc    = 0;
        int nbusy  = 0;
        int nready = 0;
        bit got    = 1'b0;
        while (cyc < 40 && !got) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) nbusy++;
                if (bus.ready) nready++;
                if (cyc == inj) begin
                    bus.start = 1'b1;
                    bus.a     = 32'd9;
                    bus.b     = 32'd9;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check({nm, " done seen"}, 64'(got), 64'd1);
        check({nm, " latency"}, 64'(cyc + 1), 64'd33);
        check({nm, " busy cycles"}, 64'(nbusy), 64'd32);
        check({nm, " ready while busy"}, 64'(nready), 64'd0);
        check({nm, " hi"}, 64'(bus.hi), 64'(eh));
        check({nm, " lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        chk_en    = 1'b0;
        m_in      = 1'b0;
        m_k       = 0;
        m_a       = '0;
        m_b       = '0;
        m_hold    = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset ctrl", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
        check("reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);

        launch(32'd3, 32'd5);
        wait_done(32'h0, 32'h0000000F, "3x5", -1);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(32'hFFFFFFFE, 32'h00000001, "max x max", -1);
        @(negedge clk);
        launch(32'h12345678, 32'h0);
        wait_done(32'h0, 32'h0, "a x 0", -1);
        launch(32'h0, 32'hDEADBEEF);
        wait_done(32'h0, 32'h0, "0 x b", -1);
        launch(32'h80000000, 32'd2);
        wait_done(32'h1, 32'h0, "msb x 2", -1);
        repeat (3) @(negedge clk);
        check("hold after idle", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);

        launch(32'd7, 32'd6);
        wait_done(32'h0, 32'd42, "start ignored", 10);

        launch(32'h10000, 32'h10000);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort ctrl", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
        check("abort hi:lo", {bus.hi, bus.lo}, 64'd0);
        begin
            int ndone = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.done) ndone++;
            end
            check("abort no done", 64'(ndone), 64'd0);
        end
        launch(32'd2, 32'd3);
        wait_done(32'h0, 32'd6, "after abort", -1);

        launch(32'd5, 32'd7);
        wait_done(32'h0, 32'd35, "b2b first", -1);
        launch(32'h100, 32'h100);
        check("b2b no idle", 64'(bus.busy), 64'd1);
        wait_done(32'h0, 32'h10000, "b2b second", -1);
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel       = int'($urandom_range(0, 7));
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = (sel == 0) ? 32'hFFFFFFFF : (sel == 1) ? 32'h0 : $urandom;
            bus.b     = (sel == 2) ? 32'hFFFFFFFF : (sel == 3) ? 32'h80000001 : $urandom;
            reset     = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Multi-cycle unsigned 32x32->64 shift-and-add multiplier sequencer for the CPU datapath.
It instantiates one add_new ripple-carry adder and reuses it once per cycle for the partial-product accumulation.
An FSM with a start/busy/done handshake drives the adder, the shift registers and the iteration counter.
It is the MUL execution unit that feeds the HI/LO registers.

Parameters:
WIDTH, 32, operand width; must be 32 (add_new is fixed at 32 bits); any other value is unsupported.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only when ready=1
a  input  32  multiplicand (unsigned); captured on the accepting edge
b  input  32  multiplier (unsigned); captured on the accepting edge
ready  output  1  1 in IDLE and DONE; start is accepted only when ready=1
busy  output  1  1 while iterating
done  output  1  one-cycle pulse; the product is valid from this cycle onward
hi  output  32  product bits [63:32]
lo  output  32  product bits [31:0]

Behaviour:
- Reset (synchronous, active high) forces the following on the next edge, regardless of state:
  - state = IDLE, counter = 0, multiplicand register = 0, hi = 0, lo = 0
  - busy = 0, done = 0, ready = 1
- A reset asserted mid-operation aborts the multiply. No done pulse is produced.
- States:
  - IDLE:
    - ready = 1.
    - If start=1 at an edge: mcand <= a, hi <= 0, lo <= b, counter <= 0, go to BUSY.
  - BUSY:
    - busy = 1, ready = 0.
    - Each edge performs one iteration:
      - Adder inputs: x = hi, y = (lo[0] ? mcand : 0). This gives sum s and carry c_out.
      - {hi, lo} <= {c_out, s, lo[31:1]}, a 65-bit right shift with the carry entering at bit 63.
      - counter <= counter + 1.
    - On the edge where counter == 31 (the 32nd iteration), go to DONE.
    - start is ignored while BUSY. The operands captured at entry are unaffected.
  - DONE:
    - done = 1 for exactly this one cycle, ready = 1, and {hi, lo} holds the final product.
    - If start=1 at this edge: a new operation is accepted immediately with the same actions as IDLE, going to BUSY (back-to-back throughput).
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0; BUSY covers edges E1..E32; done is high in the cycle after E32. That is 33 cycles from the accepting edge to done.
- Output hold: hi/lo keep the last product through IDLE until the next accepted start. From that start edge they show intermediate values.
- Arithmetic:
  - Unsigned only, no truncation; the full 64-bit product is always exact.
  - The adder carry must never be dropped. c_out becomes bit 31 of hi after the shift.
  - A signed MUL is handled by the caller and is out of scope here.
- Counter: counts 0..31 in BUSY and must not wrap within an operation. It is reset to 0 on each accepted start.
- Simultaneous reset and start: reset wins; state = IDLE and the start is dropped.
- The adder is instantiated exactly once. No other adder or multiplier operator is allowed in this block.

Test Plan:
- reset; start with a=3, b=5 -> done pulses 33 cycles after the accepting edge; hi=0x00000000, lo=0x0000000F; busy=1 for exactly 32 cycles.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. This exercises the adder c_out on every iteration.
- a=0x12345678, b=0 -> hi=0, lo=0. Then a=0, b=0xDEADBEEF -> hi=0, lo=0. Also run a=0x80000000, b=2 -> hi=0x00000001, lo=0.
- Start a=7, b=6; pulse start with a=9, b=9 at iteration 10 -> the second start is ignored; result hi=0, lo=42; ready stays 0 until done.
- Start a=0x10000, b=0x10000; assert reset at iteration 15 -> next cycle: IDLE, hi=lo=0, busy=0, no done pulse. A following start with a=2, b=3 -> lo=6.
- Hold start=1 in the DONE cycle with new operands a=0x100, b=0x100 -> accepted with no IDLE cycle between; second done 33 cycles later with hi=0, lo=0x10000; first product is visible during the first done.
